// File: rtl/syn_current_acc.sv
// ---------------------------------------------------------------------------
// syn_current_acc
//
// Per-neuron synaptic current accumulator. On each timestep pulse it latches
// the presynaptic spike vector, walks the weight RAM once (one address per
// cycle), and adds the weight lane of every spiking input into a saturating
// signed accumulator. The result is registered onto `current` and flagged by
// a one-cycle `done` strobe for the neuron update stage.
//
// Optional feature macro: SYN_DECAY_EN
//   defined   - accumulator is seeded with current - (current >>> DECAY_SHIFT)
//               so the synaptic current decays exponentially between steps
//   undefined - accumulator is seeded with zero each timestep
//
// Ports
//   clk        in   1             system clock, rising edge
//   rst        in   1             asynchronous reset, active-high
//   start      in   1             timestep pulse; latches spike_vec when idle
//   spike_vec  in   N_INPUTS      bit k = presynaptic input k fired
//   dpra       out  NEURON_ADR+1  weight RAM read address
//   dpo        in   WEIGHTS+1     weight RAM read data (combinational)
//   busy       out  1             scan in progress (SCAN and DONE states)
//   done       out  1             one-cycle strobe; current valid
//   current    out  ACC_W         signed synaptic current, held until next done
// ---------------------------------------------------------------------------
module syn_current_acc #(
    parameter int WIDTH       = 8,
    parameter int NEURON_ADR  = 5,
    parameter int WEIGHTS     = 31,
    parameter int LANE        = 0,
    parameter int N_INPUTS    = 64,
    parameter int ACC_W       = 16,
    parameter int DECAY_SHIFT = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [N_INPUTS-1:0]     spike_vec,
    output logic [NEURON_ADR:0]     dpra,
    input  logic [WEIGHTS:0]        dpo,
    output logic                    busy,
    output logic                    done,
    output logic signed [ACC_W-1:0] current
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    localparam logic [NEURON_ADR:0] LAST_IDX = (NEURON_ADR + 1)'(N_INPUTS - 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t                  state;
    state_t                  state_nx;
    logic [NEURON_ADR:0]     idx;
    logic [N_INPUTS-1:0]     spike_q;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] seed;
    logic signed [ACC_W-1:0] acc_sat;
    logic signed [WIDTH-1:0] w_lane;
    logic signed [ACC_W:0]   w_ext;
    logic signed [ACC_W:0]   sum;
    logic                    last_idx;
    logic                    unused_cfg;

    // Only one lane of the RAM word feeds this neuron; the other lanes and
    // the decay shift (when decay is compiled out) are intentionally ignored.
    assign unused_cfg = ^{dpo, 32'(DECAY_SHIFT)};

    assign dpra     = idx;
    assign busy     = (state != S_IDLE);
    assign last_idx = (idx == LAST_IDX);

    // Saturating add evaluated one bit wider than the accumulator; a sign
    // mismatch between the top two bits of the sum indicates overflow.
    always_comb begin
        w_lane  = dpo[LANE*WIDTH +: WIDTH];
        w_ext   = {{(ACC_W + 1 - WIDTH){w_lane[WIDTH-1]}}, w_lane};
        sum     = {acc[ACC_W-1], acc} + w_ext;
        acc_sat = sum[ACC_W-1:0];
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            acc_sat = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

`ifdef SYN_DECAY_EN
    always_comb begin
        seed = current - (current >>> DECAY_SHIFT);
    end
`else
    always_comb begin
        seed = '0;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = S_SCAN;
            S_SCAN: if (last_idx) state_nx = S_DONE;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // idx stops at the last address so dpra holds its final value while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx     <= '0;
            acc     <= '0;
            current <= '0;
            done    <= 1'b0;
            spike_q <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        spike_q <= spike_vec;
                        idx     <= '0;
                        acc     <= seed;
                    end
                end
                S_SCAN: begin
                    if (spike_q[idx]) begin
                        acc <= acc_sat;
                    end
                    if (!last_idx) begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    current <= acc;
                    done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_syn_current_acc.sv
module tb_syn_current_acc;

`ifdef SYN_DECAY_EN
    localparam bit DECAY_EN = 1'b1;
`else
    localparam bit DECAY_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start_a, start_b;
    logic [63:0] spike_a, spike_b;
    logic [5:0]  dpra_a, dpra_b;
    logic [31:0] dpo_a, dpo_b;
    logic        busy_a, busy_b;
    logic        done_a, done_b;
    logic signed [15:0] cur_a;
    logic signed [11:0] cur_b;

    logic [31:0] ram [64];

    int checks = 0;
    int errors = 0;
    int exp_a  = 0;   // model's view of the previous current (decay seed)
    int exp_b  = 0;

    assign dpo_a = ram[dpra_a];
    assign dpo_b = ram[dpra_b];

    syn_current_acc dut_a (
        .clk(clk), .rst(rst), .start(start_a), .spike_vec(spike_a),
        .dpra(dpra_a), .dpo(dpo_a), .busy(busy_a), .done(done_a), .current(cur_a)
    );

    syn_current_acc #(.ACC_W(12)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .spike_vec(spike_b),
        .dpra(dpra_b), .dpo(dpo_b), .busy(busy_b), .done(done_b), .current(cur_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: seed, then add each spiking input's signed lane-0 weight,
    // clamping to the accumulator range after every addition.
    function automatic int model(input logic [63:0] sv, input int prev, input int accw);
        int acc, hi, lo;
        logic signed [7:0] l;
        hi  = (1 << (accw - 1)) - 1;
        lo  = -(1 << (accw - 1));
        acc = DECAY_EN ? prev - (prev >>> 2) : 0;
        for (int k = 0; k < 64; k++) begin
            if (sv[k]) begin
                l   = ram[k][7:0];
                acc = acc + int'(l);
                if (acc > hi) acc = hi;
                if (acc < lo) acc = lo;
            end
        end
        return acc;
    endfunction

    // Drives one timestep and records what the DUT did (no judging here).
    task automatic run_scan(input int which, input logic [63:0] sv,
                            output int done_cyc, output int n_done,
                            output int busy_bad, output int dpra_bad);
        logic d, b;
        logic [5:0] dp;
        done_cyc = -1; n_done = 0; busy_bad = 0; dpra_bad = 0;
        @(negedge clk);
        if (which == 0) begin start_a = 1'b1; spike_a = sv; end
        else begin start_b = 1'b1; spike_b = sv; end
        for (int c = 1; c <= 72; c++) begin
            @(negedge clk);
            start_a = 1'b0; start_b = 1'b0;
            d  = (which == 0) ? done_a : done_b;
            b  = (which == 0) ? busy_a : busy_b;
            dp = (which == 0) ? dpra_a : dpra_b;
            if (d) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (b !== (c <= 65)) busy_bad++;
            if (c <= 64 && dp !== 6'(c - 1)) dpra_bad++;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_a = 0; exp_b = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; spike_a = '0; spike_b = '0;
        repeat (2) @(negedge clk);
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done_a); end
        checks++; if (cur_a !== 16'sd0) begin errors++; $display("FAIL reset_current got %0d want 0", cur_a); end
        checks++; if (dpra_a !== 6'd0) begin errors++; $display("FAIL reset_dpra got %0d want 0", dpra_a); end
        checks++; if (cur_b !== 12'sd0 || busy_b !== 1'b0) begin errors++; $display("FAIL reset_b got cur=%0d busy=%0b want 0/0", cur_b, busy_b); end
        rst = 1'b0;
        exp_a = 0; exp_b = 0;
    endtask

    task automatic test_basic();
        int dc, nd, bb, db, got, want;
        for (int k = 0; k < 64; k++) ram[k] = {$urandom_range(0, 16777215), 8'(k)};
        want = model(64'h28, exp_a, 16);
        run_scan(0, 64'h28, dc, nd, bb, db);
        got = cur_a;
        checks++; if (dc !== 66) begin errors++; $display("FAIL basic_latency got %0d want 66", dc); end
        checks++; if (nd !== 1) begin errors++; $display("FAIL basic_done_count got %0d want 1", nd); end
        checks++; if (bb !== 0) begin errors++; $display("FAIL basic_busy_window got %0d bad cycles want 0", bb); end
        checks++; if (got !== want || got !== 8) begin errors++; $display("FAIL basic_current got %0d want %0d (8)", got, want); end
        exp_a = want;
    endtask

    task automatic test_zero_dpra();
        int dc, nd, bb, db, got, want;
        want = model(64'h0, exp_a, 16);
        run_scan(0, 64'h0, dc, nd, bb, db);
        got = cur_a;
        checks++; if (db !== 0) begin errors++; $display("FAIL zero_dpra_walk got %0d bad cycles want 0", db); end
        checks++; if (got !== want) begin errors++; $display("FAIL zero_current got %0d want %0d", got, want); end
        checks++; if (dpra_a !== 6'd63) begin errors++; $display("FAIL zero_dpra_hold got %0d want 63", dpra_a); end
        exp_a = want;
    endtask

    task automatic test_saturation();
        int dc, nd, bb, db, got, want;
        for (int k = 0; k < 64; k++) ram[k] = {24'h5A5A5A, 8'h7F};
        want = model('1, exp_b, 12);
        run_scan(1, '1, dc, nd, bb, db);
        got = cur_b;
        checks++; if (got !== want || got !== 2047) begin errors++; $display("FAIL sat_high got %0d want %0d (2047)", got, want); end
        exp_b = want;
        for (int k = 0; k < 64; k++) ram[k] = {24'h123456, 8'h80};
        want = model('1, exp_b, 12);
        run_scan(1, '1, dc, nd, bb, db);
        got = cur_b;
        checks++; if (got !== want || got !== -2048) begin errors++; $display("FAIL sat_low got %0d want %0d (-2048)", got, want); end
        exp_b = want;
        // Clamp during the positive half must influence the final result.
        for (int k = 0; k < 64; k++) ram[k] = {24'h0, (k < 32) ? 8'h7F : 8'h80};
        want = model('1, exp_b, 12);
        run_scan(1, '1, dc, nd, bb, db);
        got = cur_b;
        checks++; if (got !== want) begin errors++; $display("FAIL sat_every_add got %0d want %0d", got, want); end
        checks++; if (dc !== 66 || bb !== 0) begin errors++; $display("FAIL sat_timing got done=%0d busybad=%0d want 66/0", dc, bb); end
        exp_b = want;
    endtask

    task automatic test_random();
        int dc, nd, bb, db, got, want;
        logic [63:0] sv;
        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < 64; k++) ram[k] = $urandom;
            sv = {$urandom, $urandom};
            if (it % 2 == 0) begin
                want = model(sv, exp_a, 16);
                run_scan(0, sv, dc, nd, bb, db);
                got = cur_a;
                exp_a = want;
            end else begin
                want = model(sv, exp_b, 12);
                run_scan(1, sv, dc, nd, bb, db);
                got = cur_b;
                exp_b = want;
            end
            checks++; if (got !== want || nd !== 1) begin errors++; $display("FAIL random_%0d got %0d (dones %0d) want %0d (1)", it, got, nd, want); end
        end
    endtask

    task automatic test_start_ignored();
        int dc, nd, got, want;
        logic [63:0] sv1, sv2;
        for (int k = 0; k < 64; k++) ram[k] = $urandom;
        sv1 = {$urandom, $urandom};
        sv2 = ~sv1;
        want = model(sv1, exp_a, 16);
        dc = -1; nd = 0;
        @(negedge clk);
        start_a = 1'b1; spike_a = sv1;
        for (int c = 1; c <= 75; c++) begin
            @(negedge clk);
            start_a = (c == 10);
            spike_a = sv2;
            if (done_a) begin nd++; if (dc < 0) dc = c; end
        end
        got = cur_a;
        checks++; if (dc !== 66 || nd !== 1) begin errors++; $display("FAIL ignore_start got done_cyc=%0d n=%0d want 66/1", dc, nd); end
        checks++; if (got !== want) begin errors++; $display("FAIL ignore_start_value got %0d want %0d", got, want); end
        exp_a = want;
    endtask

    task automatic test_back_to_back();
        int dc, nd, got, want1, want2, guard;
        logic [63:0] sv1, sv2;
        for (int k = 0; k < 64; k++) ram[k] = $urandom;
        sv1 = {$urandom, $urandom};
        sv2 = {$urandom, $urandom};
        want1 = model(sv1, exp_a, 16);
        @(negedge clk);
        start_a = 1'b1; spike_a = sv1;
        @(negedge clk);
        start_a = 1'b0;
        guard = 0;
        while (done_a !== 1'b1 && guard < 80) begin
            @(negedge clk);
            guard++;
        end
        got = cur_a;
        checks++; if (done_a !== 1'b1 || got !== want1) begin errors++; $display("FAIL b2b_first got done=%0b cur=%0d want 1/%0d", done_a, got, want1); end
        want2 = model(sv2, want1, 16);
        start_a = 1'b1; spike_a = sv2;   // same cycle as done
        dc = -1; nd = 0;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (done_a) begin nd++; if (dc < 0) dc = c; end
        end
        got = cur_a;
        checks++; if (dc !== 66 || nd !== 1) begin errors++; $display("FAIL b2b_second_timing got done_cyc=%0d n=%0d want 66/1", dc, nd); end
        checks++; if (got !== want2) begin errors++; $display("FAIL b2b_second_value got %0d want %0d", got, want2); end
        exp_a = want2;
    endtask

    task automatic test_reset_mid_scan();
        int dc, nd, bb, db, got, want;
        logic [63:0] sv;
        for (int k = 0; k < 64; k++) ram[k] = $urandom;
        sv = {$urandom, $urandom};
        @(negedge clk);
        start_a = 1'b1; spike_a = sv;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start_a = 1'b0;
        end
        rst = 1'b1;
        #1;
        checks++; if (busy_a !== 1'b0 || cur_a !== 16'sd0) begin errors++; $display("FAIL midreset_outputs got busy=%0b cur=%0d want 0/0", busy_a, cur_a); end
        checks++; if (dpra_a !== 6'd0 || done_a !== 1'b0) begin errors++; $display("FAIL midreset_dpra got dpra=%0d done=%0b want 0/0", dpra_a, done_a); end
        @(negedge clk);
        rst = 1'b0;
        exp_a = 0; exp_b = 0;
        nd = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (done_a) nd++;
        end
        checks++; if (nd !== 0) begin errors++; $display("FAIL midreset_no_done got %0d pulses want 0", nd); end
        want = model(sv, exp_a, 16);
        run_scan(0, sv, dc, nd, bb, db);
        got = cur_a;
        checks++; if (got !== want || dc !== 66) begin errors++; $display("FAIL midreset_recover got %0d at %0d want %0d at 66", got, dc, want); end
        exp_a = want;
    endtask

    task automatic test_decay();
        int dc, nd, bb, db, got, want;
        pulse_reset();
        for (int k = 0; k < 64; k++) ram[k] = $urandom;
        ram[0] = {24'hABCDEF, 8'd100};
        want = model(64'h1, exp_a, 16);
        run_scan(0, 64'h1, dc, nd, bb, db);
        got = cur_a;
        checks++; if (got !== 100 || got !== want) begin errors++; $display("FAIL decay_prior got %0d want 100", got); end
        exp_a = want;
        want = model(64'h0, exp_a, 16);
        run_scan(0, 64'h0, dc, nd, bb, db);
        got = cur_a;
        checks++; if (got !== want || got !== (DECAY_EN ? 75 : 0)) begin errors++; $display("FAIL decay_step got %0d want %0d", got, want); end
        exp_a = want;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_dpra();
        test_saturation();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_scan();
        test_decay();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
